pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Detects load-use hazards between IF/ID and ID/EX and freezes PC and IF/ID for one cycle. While frozen it injects a bubble into ID/EX by zeroing its control inputs.
- Flushes IF/ID on a taken branch.
- Freezes the whole pipeline while a data-memory access waits for ready.
- Sits beside the ID stage and drives the enable and clear inputs of the PC, IF/ID and ID/EX registers.

Parameters:
- REG_ADDR_W, 5, register address width.
- MEM_WAIT_MAX, 16, MEM_WAIT cycle count at which mem_timeout_o is set.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- IFID_RS1addr_i  in  REG_ADDR_W  rs1 of the instruction in ID
- IFID_RS2addr_i  in  REG_ADDR_W  rs2 of the instruction in ID
- IDEX_RDaddr_i  in  REG_ADDR_W  rd of the instruction in EX
- IDEX_MemRead_i  in  1  instruction in EX is a load
- branch_taken_i  in  1  branch resolved taken in ID
- dmem_req_i  in  1  MEM stage is accessing data memory
- dmem_ready_i  in  1  data memory completes the access this cycle
- PCWrite_o  out  1  PC load enable
- IFIDWrite_o  out  1  IF/ID load enable
- IDEX_bubble_o  out  1  zero ID/EX control inputs (ALUsrc, ALUOp, MemWrite, MemRead, MemtoReg)
- IFID_flush_o  out  1  clear IF/ID to a NOP
- stall_all_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB
- mem_timeout_o  out  1  sticky: a memory wait reached MEM_WAIT_MAX

Behaviour:
- Reset: clock clk_i; rst_n_i is asynchronous, active-low. While rst_n_i=0: state=INIT, wait_cnt=0, mem_timeout_o=0.
- FSM states: INIT, RUN, MEM_WAIT. State is registered; control outputs are combinational from state and inputs (zero-cycle latency to the registers they drive).
- INIT: exactly one cycle after reset release.
  - Outputs: PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=1, IFID_flush_o=1, stall_all_o=0.
  - Next state: RUN.
- Hazard term: lu = IDEX_MemRead_i & (IDEX_RDaddr_i != 0) & (IDEX_RDaddr_i == IFID_RS1addr_i | IDEX_RDaddr_i == IFID_RS2addr_i).
  - rd = x0 never causes a hazard.
- RUN, priority order:
  1. Memory wait: if dmem_req_i & ~dmem_ready_i, then stall_all_o=1, PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=0, IFID_flush_o=0; next state MEM_WAIT, wait_cnt<=1.
  2. Load-use: else if lu, then PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=1. IFID_flush_o=0, even if branch_taken_i=1; the branch is re-evaluated next cycle with correct operands.
  3. Branch: else if branch_taken_i, then IFID_flush_o=1, PCWrite_o=1, IFIDWrite_o=1.
  4. Default: PCWrite_o=1, IFIDWrite_o=1, all others 0.
- dmem_req_i & dmem_ready_i in the same cycle: no stall.
- MEM_WAIT:
  - While dmem_ready_i=0: stall_all_o=1, PCWrite_o=0, IFIDWrite_o=0, bubble and flush 0, wait_cnt increments (saturating).
  - When wait_cnt reaches MEM_WAIT_MAX: mem_timeout_o<=1 on that edge; it stays 1 until reset. The stall continues.
  - When dmem_ready_i=1: stall_all_o=0 that cycle and outputs follow the RUN rules 2–4, so hazard and branch terms are evaluated on the frozen values. Next state RUN, wait_cnt<=0.
- dmem_req_i dropping to 0 in MEM_WAIT is treated as ready (abort): exit as above.
- Reset asserted mid-stall: immediate return to INIT; a pending stall or flush is discarded.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs lu_stall_cnt_o [CNT_W] (+1 per cycle where rule 2 fires) and mem_wait_cnt_o [CNT_W] (+1 per cycle with stall_all_o=1).
  - Counters are reset to 0 by rst_n_i and wrap at 2^CNT_W.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum (INIT, RUN, MEM_WAIT), REG_ADDR_W default, NOP instruction constant used by IF/ID flush.
- One sub-module is natural: hazard_detect, purely combinational, computing lu from the four address/MemRead inputs. It can be reused by a later forwarding unit.

Test Plan:
- Reset release → INIT for 1 cycle (PCWrite_o=0, IFID_flush_o=1, IDEX_bubble_o=1), then RUN with PCWrite_o=1.
- IDEX_MemRead_i=1, IDEX_RDaddr_i=5, IFID_RS2addr_i=5 → exactly 1 cycle of PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=1. Repeat with RDaddr=0 → no stall.
- branch_taken_i=1 with no hazard → IFID_flush_o=1, PCWrite_o=1 for 1 cycle. Same with the load-use condition true → bubble only, flush=0.
- dmem_req_i=1, dmem_ready_i low for 3 cycles then high → stall_all_o=1 for exactly 3 cycles, 0 on the ready cycle, state back to RUN.
- dmem_ready_i held low 20 cycles with MEM_WAIT_MAX=16 → mem_timeout_o rises after the 16th wait cycle and stays 1 after ready; cleared only by rst_n_i=0.
- rst_n_i pulsed low asynchronously during MEM_WAIT → stall_all_o=0 immediately, INIT on release. With HAZARD_PERF_CNT_EN, both counters read 0 after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller and its helpers.
//   ctrl_state_e      : controller FSM states (INIT, RUN, MEM_WAIT)
//   REG_ADDR_W_DFLT   : default register address width
//   MEM_WAIT_MAX_DFLT : default memory-wait count that raises the timeout flag
//   NOP_INSTR         : instruction word loaded into IF/ID when it is flushed
//                       (addi x0, x0, 0)
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_e;

    localparam int REG_ADDR_W_DFLT   = 5;
    localparam int MEM_WAIT_MAX_DFLT = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard detector. Kept separate so a later
// forwarding unit can reuse the same comparison.
// Ports:
//   rs1_addr_i  : rs1 of the instruction in ID
//   rs2_addr_i  : rs2 of the instruction in ID
//   rd_addr_i   : rd of the instruction in EX
//   mem_read_i  : instruction in EX is a load
//   lu_o        : load-use hazard present
// ----------------------------------------------------------------------------
module hazard_detect #(
    parameter int ADDR_W = pipe_ctrl_pkg::REG_ADDR_W_DFLT
) (
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              mem_read_i,
    output logic              lu_o
);

    // x0 is hard-wired to zero, so a load targeting it can never feed a consumer.
    assign lu_o = mem_read_i
                & (rd_addr_i != '0)
                & ((rd_addr_i == rs1_addr_i) | (rd_addr_i == rs2_addr_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Sits beside ID and
// drives the enable/clear inputs of the PC, IF/ID and ID/EX registers.
// Control outputs are combinational from the registered state and the inputs.
// Ports:
//   clk_i, rst_n_i              : clock (rising edge), async active-low reset
//   IFID_RS1addr_i/RS2addr_i    : source registers of the instruction in ID
//   IDEX_RDaddr_i, IDEX_MemRead_i : destination / load flag of the instruction in EX
//   branch_taken_i              : branch resolved taken in ID
//   dmem_req_i, dmem_ready_i    : data-memory access handshake from MEM
//   PCWrite_o, IFIDWrite_o      : load enables for PC and IF/ID
//   IDEX_bubble_o               : zero the ID/EX control inputs
//   IFID_flush_o                : clear IF/ID to a NOP
//   stall_all_o                 : freeze every pipeline register
//   mem_timeout_o               : sticky flag, a memory wait reached MEM_WAIT_MAX
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   lu_stall_cnt_o, mem_wait_cnt_o : wrapping performance counters of width CNT_W
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DFLT,
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DFLT
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] IFID_RS1addr_i,
    input  logic [REG_ADDR_W-1:0] IFID_RS2addr_i,
    input  logic [REG_ADDR_W-1:0] IDEX_RDaddr_i,
    input  logic                  IDEX_MemRead_i,
    input  logic                  branch_taken_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ready_i,
    output logic                  PCWrite_o,
    output logic                  IFIDWrite_o,
    output logic                  IDEX_bubble_o,
    output logic                  IFID_flush_o,
    output logic                  stall_all_o,
    output logic                  mem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      lu_stall_cnt_o,
    output logic [CNT_W-1:0]      mem_wait_cnt_o
`endif
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT_MAX);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              lu;
    logic              mem_stall;

    hazard_detect #(
        .ADDR_W     (REG_ADDR_W)
    ) u_hazard_detect (
        .rs1_addr_i (IFID_RS1addr_i),
        .rs2_addr_i (IFID_RS2addr_i),
        .rd_addr_i  (IDEX_RDaddr_i),
        .mem_read_i (IDEX_MemRead_i),
        .lu_o       (lu)
    );

    // A request with dmem_req_i low is treated as complete, which also covers
    // an aborted access while waiting.
    assign mem_stall = dmem_req_i & ~dmem_ready_i;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        PCWrite_o     = 1'b0;
        IFIDWrite_o   = 1'b0;
        IDEX_bubble_o = 1'b0;
        IFID_flush_o  = 1'b0;
        stall_all_o   = 1'b0;

        case (state_q)
            INIT: begin
                IDEX_bubble_o = 1'b1;
                IFID_flush_o  = 1'b1;
                state_d       = RUN;
            end

            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    // wait_cnt is 0 in RUN, so the saturating increment yields 1
                    // on entry and counts each further stalled cycle.
                    stall_all_o = 1'b1;
                    state_d     = MEM_WAIT;
                    wait_cnt_d  = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX
                                                           : wait_cnt_q + WAIT_W'(1);
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    // A taken branch under a load-use hazard is not flushed: it is
                    // re-evaluated next cycle once the load data is available.
                    if (lu) begin
                        IDEX_bubble_o = 1'b1;
                    end else if (branch_taken_i) begin
                        IFID_flush_o = 1'b1;
                        PCWrite_o    = 1'b1;
                        IFIDWrite_o  = 1'b1;
                    end else begin
                        PCWrite_o    = 1'b1;
                        IFIDWrite_o  = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = INIT;
                wait_cnt_d = '0;
            end
        endcase

        mem_timeout_d = mem_timeout_q | (stall_all_o & (wait_cnt_d == WAIT_MAX));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= INIT;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout_o = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic             lu_fire;
    logic [CNT_W-1:0] lu_stall_cnt_q, lu_stall_cnt_d;
    logic [CNT_W-1:0] mem_wait_cnt_q, mem_wait_cnt_d;

    // Load-use rule fires only outside INIT and when no memory stall overrides it.
    assign lu_fire = (state_q != INIT) & ~mem_stall & lu;

    always_comb begin
        lu_stall_cnt_d = lu_stall_cnt_q + {{(CNT_W-1){1'b0}}, lu_fire};
        mem_wait_cnt_d = mem_wait_cnt_q + {{(CNT_W-1){1'b0}}, stall_all_o};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lu_stall_cnt_q <= '0;
            mem_wait_cnt_q <= '0;
        end else begin
            lu_stall_cnt_q <= lu_stall_cnt_d;
            mem_wait_cnt_q <= mem_wait_cnt_d;
        end
    end

    assign lu_stall_cnt_o = lu_stall_cnt_q;
    assign mem_wait_cnt_o = mem_wait_cnt_q;
`endif

endmodule
